// File: rtl/psum_accum.sv
// psum_accum - partial-sum accumulator behind the 3x3 PE array.
//
// Sums a LANES-wide vector of signed Q(IW).(FW) partial sums over successive
// input-channel beats. On the last beat of a group it adds the bias, applies
// optional ReLU, and holds the finished vector on a valid/ready output until
// it is taken. Every addition saturates instead of wrapping.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   psum_i         LANES packed signed partial sums, lane k at [k*W +: W]
//   psum_valid_i   beat valid
//   psum_ready_o   beat can be accepted (high only while accumulating)
//   first_i        beat starts a new group (qualified by psum_valid_i)
//   last_i         beat ends the group (qualified by psum_valid_i)
//   bias_i         signed bias, sampled with the last beat
//   relu_en_i      ReLU enable, sampled with the last beat
//   res_o          finished results, same packing as psum_i
//   res_valid_o    result valid
//   res_ready_i    consumer takes the result
//   sat_o          some addition in the result's group clamped
//   beats_o        beat count of the result's group (saturating)
module psum_accum #(
   parameter int unsigned LANES = 9,
   parameter int unsigned IW    = 24,
   parameter int unsigned FW    = 8,
   parameter int unsigned CW    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [LANES*(IW+FW)-1:0]  psum_i,
   input  logic                      psum_valid_i,
   output logic                      psum_ready_o,
   input  logic                      first_i,
   input  logic                      last_i,
   input  logic [IW+FW-1:0]          bias_i,
   input  logic                      relu_en_i,
   output logic [LANES*(IW+FW)-1:0]  res_o,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic                      sat_o,
   output logic [CW-1:0]             beats_o
);

   localparam int unsigned W = IW + FW;
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {ACC, HOLD} state_t;

   state_t state, state_next;
   logic   accept;

   logic [W-1:0]       acc [LANES];
   logic               sat_grp;
   logic [CW-1:0]      cnt;

   logic [W-1:0]       sum [LANES];
   logic [LANES*W-1:0] fin;
   logic               sum_clamp;
   logic               fin_clamp;
   logic [W-1:0]       base;
   logic [W:0]         ext_sum;
   logic [W:0]         ext_fin;
   logic [W-1:0]       fv;
   logic [CW-1:0]      cnt_base;
   logic [CW-1:0]      cnt_next;
   logic               sat_next;
   logic               sat_final;

   // Sign-extended add: one extra bit can never overflow, so a mismatch of
   // the top two bits means the W-bit result must be clamped.
   function automatic logic [W:0] add_ext(input logic [W-1:0] a, input logic [W-1:0] b);
      return {a[W-1], a} + {b[W-1], b};
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      unique case (state)
         ACC:  if (accept && last_i) state_next = HOLD;
         HOLD: if (res_ready_i)      state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      psum_ready_o = (state == ACC);
   end

   assign accept = psum_valid_i & psum_ready_o;

   // ---------------- Lane arithmetic ----------------
   always_comb begin
      sum_clamp = 1'b0;
      fin_clamp = 1'b0;
      fin       = '0;
      base      = '0;
      ext_sum   = '0;
      ext_fin   = '0;
      fv        = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         base    = first_i ? '0 : acc[k];
         ext_sum = add_ext(base, psum_i[k*W +: W]);
         sum[k]  = ext_sum[W-1:0];
         if (ext_sum[W] != ext_sum[W-1]) begin
            sum[k]    = ext_sum[W] ? MINV : MAXV;
            sum_clamp = 1'b1;
         end
         ext_fin = add_ext(sum[k], bias_i);
         fv      = ext_fin[W-1:0];
         if (ext_fin[W] != ext_fin[W-1]) begin
            fv        = ext_fin[W] ? MINV : MAXV;
            fin_clamp = 1'b1;
         end
         if (relu_en_i && fv[W-1]) fv = '0;
         fin[k*W +: W] = fv;
      end
   end

   always_comb begin
      cnt_base  = first_i ? '0 : cnt;
      cnt_next  = (&cnt_base) ? cnt_base : cnt_base + CW'(1);
      sat_next  = (first_i ? 1'b0 : sat_grp) | sum_clamp;
      sat_final = sat_next | fin_clamp;
   end

   // ---------------- Accumulator and result registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < LANES; k++) acc[k] <= '0;
         sat_grp     <= 1'b0;
         cnt         <= '0;
         res_o       <= '0;
         res_valid_o <= 1'b0;
         sat_o       <= 1'b0;
         beats_o     <= '0;
      end else if (accept) begin
         if (last_i) begin
            for (int unsigned k = 0; k < LANES; k++) acc[k] <= '0;
            sat_grp     <= 1'b0;
            cnt         <= '0;
            res_o       <= fin;
            sat_o       <= sat_final;
            beats_o     <= cnt_next;
            res_valid_o <= 1'b1;
         end else begin
            for (int unsigned k = 0; k < LANES; k++) acc[k] <= sum[k];
            sat_grp <= sat_next;
            cnt     <= cnt_next;
         end
      end else if (res_valid_o && res_ready_i) begin
         res_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;

   localparam int LANES = 9;
   localparam int W     = 32;
   localparam int CW    = 16;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [LANES*W-1:0]   psum_i;
   logic                 psum_valid_i;
   logic                 psum_ready_o;
   logic                 first_i;
   logic                 last_i;
   logic [W-1:0]         bias_i;
   logic                 relu_en_i;
   logic [LANES*W-1:0]   res_o;
   logic                 res_valid_o;
   logic                 res_ready_i;
   logic                 sat_o;
   logic [CW-1:0]        beats_o;

   psum_accum #(.LANES(LANES), .IW(24), .FW(8), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
      .first_i(first_i), .last_i(last_i), .bias_i(bias_i), .relu_en_i(relu_en_i),
      .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .sat_o(sat_o), .beats_o(beats_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: running group state in plain integers.
   longint beat_p [LANES];
   longint m_acc  [LANES];
   bit     m_sat;
   int     m_cnt;
   longint e_res  [LANES];
   bit     e_sat;
   int     e_beats;

   function automatic longint clampv(input longint v, inout bit c);
      if (v > MAXV) begin c = 1'b1; return MAXV; end
      if (v < MINV) begin c = 1'b1; return MINV; end
      return v;
   endfunction

   function automatic longint lane(input int k);
      logic signed [W-1:0] t;
      t = res_o[k*W +: W];
      return longint'(t);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < LANES; k++) m_acc[k] = 0;
      m_sat = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_beat(input bit first, input bit last, input longint bias, input bit relu);
      longint f;
      if (first) model_clear();
      for (int k = 0; k < LANES; k++) m_acc[k] = clampv(m_acc[k] + beat_p[k], m_sat);
      if (m_cnt < 65535) m_cnt++;
      if (last) begin
         for (int k = 0; k < LANES; k++) begin
            f = clampv(m_acc[k] + bias, m_sat);
            if (relu && f < 0) f = 0;
            e_res[k] = f;
         end
         e_sat   = m_sat;
         e_beats = m_cnt;
         model_clear();
      end
   endtask

   task automatic drive_inputs(input bit first, input bit last, input longint bias, input bit relu);
      logic [63:0] tmp;
      for (int k = 0; k < LANES; k++) begin
         tmp = beat_p[k];
         psum_i[k*W +: W] = tmp[W-1:0];
      end
      tmp          = bias;
      bias_i       = tmp[W-1:0];
      first_i      = first;
      last_i       = last;
      relu_en_i    = relu;
      psum_valid_i = 1'b1;
   endtask

   // Waits (bounded) for ready, presents one beat for one accepted cycle.
   task automatic send_beat(input bit first, input bit last, input longint bias, input bit relu);
      int n = 0;
      while (psum_ready_o !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (psum_ready_o !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_timeout: psum_ready=%b required 1", psum_ready_o);
         return;
      end
      drive_inputs(first, last, bias, relu);
      @(posedge clk); #1;
      psum_valid_i = 1'b0;
      model_beat(first, last, bias, relu);
   endtask

   task automatic check_result(input string name);
      int n = 0;
      while (res_valid_o !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (res_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid: res_valid=%b required 1", name, res_valid_o);
         return;
      end
      for (int k = 0; k < LANES; k++) begin
         checks++;
         if (lane(k) !== e_res[k]) begin
            errors++;
            $display("FAIL %s_lane%0d: got %0d required %0d", name, k, lane(k), e_res[k]);
         end
      end
      checks++;
      if (sat_o !== e_sat) begin
         errors++;
         $display("FAIL %s_sat: got %b required %b", name, sat_o, e_sat);
      end
      checks++;
      if (beats_o !== CW'(e_beats)) begin
         errors++;
         $display("FAIL %s_beats: got %0d required %0d", name, beats_o, e_beats);
      end
   endtask

   // Completes the output handshake and checks the block is open again.
   task automatic take_result(input string name);
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res_valid_o !== 1'b0 || psum_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s_release: valid=%b ready=%b required 0 1", name, res_valid_o, psum_ready_o);
      end
   endtask

   task automatic set_all(input longint v);
      for (int k = 0; k < LANES; k++) beat_p[k] = v;
   endtask

   task automatic check_zero_outputs(input string name);
      checks++;
      if (res_o !== '0 || res_valid_o !== 1'b0 || sat_o !== 1'b0 || beats_o !== '0 || psum_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s: res=%h valid=%b sat=%b beats=%0d ready=%b required all 0, ready 1",
                  name, res_o, res_valid_o, sat_o, beats_o, psum_ready_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      psum_valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; relu_en_i = 1'b0;
      psum_i = '0; bias_i = '0; res_ready_i = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      set_all(64'h100);
      send_beat(1'b1, 1'b1, 64'h80, 1'b0);
      checks++;
      if (psum_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL single_ready_low: got %b required 0", psum_ready_o);
      end
      for (int k = 0; k < LANES; k++) begin
         checks++;
         if (lane(k) !== 64'h180) begin
            errors++;
            $display("FAIL single_fixed_lane%0d: got %0d required %0d", k, lane(k), 64'h180);
         end
      end
      check_result("single");
      take_result("single");
   endtask

   task automatic test_multi();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < LANES; k++) beat_p[k] = k * 256;
         send_beat(b == 0, b == 2, 0, 1'b0);
      end
      checks++;
      if (lane(4) !== 64'(3 * 4 * 256) || beats_o !== CW'(3)) begin
         errors++;
         $display("FAIL multi_fixed: lane4=%0d beats=%0d required %0d 3", lane(4), beats_o, 3 * 4 * 256);
      end
      check_result("multi");
      take_result("multi");
   endtask

   task automatic test_neg_relu();
      for (int r = 0; r < 2; r++) begin
         set_all(-512);
         for (int b = 0; b < 3; b++) send_beat(b == 0, b == 2, 0, r == 0);
         checks++;
         if (lane(0) !== ((r == 0) ? 64'sd0 : -64'sd1536)) begin
            errors++;
            $display("FAIL neg_relu%0d_fixed: got %0d", r, lane(0));
         end
         check_result(r == 0 ? "neg_relu_on" : "neg_relu_off");
         take_result("neg_relu");
      end
   endtask

   task automatic test_overflow();
      set_all(0);
      beat_p[0] = 64'h7FFFFF00;
      send_beat(1'b1, 1'b0, 0, 1'b0);
      send_beat(1'b0, 1'b1, 0, 1'b0);
      checks++;
      if (lane(0) !== MAXV || sat_o !== 1'b1) begin
         errors++;
         $display("FAIL overflow_fixed: lane0=%0d sat=%b required %0d 1", lane(0), sat_o, MAXV);
      end
      check_result("overflow");
      take_result("overflow");
      set_all(5);
      send_beat(1'b1, 1'b1, 1, 1'b0);
      checks++;
      if (sat_o !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clean_sat: got %b required 0", sat_o);
      end
      check_result("after_overflow");
      take_result("after_overflow");
      // Bias alone pushing a lane past the negative limit.
      set_all(MINV + 10);
      send_beat(1'b1, 1'b1, -100, 1'b0);
      check_result("bias_clamp");
      take_result("bias_clamp");
   endtask

   task automatic test_backpressure();
      logic [LANES*W-1:0] held;
      res_ready_i = 1'b0;
      set_all(64'h300);
      send_beat(1'b1, 1'b1, 7, 1'b0);
      check_result("bp_first");
      held = res_o;
      set_all(-64'h40);
      drive_inputs(1'b1, 1'b1, 3, 1'b1);
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (res_o !== held || res_valid_o !== 1'b1 || psum_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: res_changed=%b valid=%b ready=%b required 0 1 0",
                     res_o !== held, res_valid_o, psum_ready_o);
         end
      end
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res_valid_o !== 1'b0 || psum_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: valid=%b ready=%b required 0 1", res_valid_o, psum_ready_o);
      end
      @(posedge clk); #1;
      psum_valid_i = 1'b0;
      model_beat(1'b1, 1'b1, 3, 1'b1);
      checks++;
      if (res_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_stalled_accept: valid=%b required 1", res_valid_o);
      end
      check_result("bp_stalled");
      take_result("bp_stalled");
   endtask

   task automatic test_mid_reset();
      set_all(64'h1234);
      send_beat(1'b1, 1'b0, 0, 1'b0);
      send_beat(1'b0, 1'b0, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset_async");
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_all(64'h200);
      send_beat(1'b1, 1'b1, 0, 1'b0);
      check_result("after_reset");
      take_result("after_reset");
      // A beat without first after a completed group starts from zero.
      set_all(64'h11);
      send_beat(1'b0, 1'b1, 0, 1'b0);
      check_result("no_first");
      take_result("no_first");
   endtask

   task automatic test_random();
      int len;
      bit restart;
      longint bias;
      bit relu;
      for (int g = 0; g < 24; g++) begin
         len     = $urandom_range(1, 4);
         bias    = longint'($signed($urandom_range(0, 2047))) - 1024;
         relu    = $urandom_range(0, 1);
         restart = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < len; b++) begin
            for (int k = 0; k < LANES; k++) begin
               if ($urandom_range(0, 3) == 0)
                  beat_p[k] = longint'($signed(32'($urandom)));
               else
                  beat_p[k] = longint'($urandom_range(0, 65535)) - 32768;
            end
            // Idle cycle with junk control that must be ignored.
            if ($urandom_range(0, 2) == 0) begin
               first_i = 1'b1; last_i = 1'b1; relu_en_i = 1'b1; bias_i = $urandom;
               @(posedge clk); #1;
            end
            send_beat((b == 0 && !(g % 5 == 4)) || (restart && b == 1),
                      b == len - 1, bias, relu);
         end
         check_result("random");
         take_result("random");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_neg_relu();
      test_overflow();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule
